// File: rtl/sum_accumulator.sv
// Sums OPERAND_COUNT unsigned 20-bit operands per result over a valid/ready pair.
// Define ACC_SATURATE_EN to clamp at 20'hFFFFF instead of wrapping.

module ripple_adder20 (
    input  logic [19:0] A,
    input  logic [19:0] B,
    input  logic        Cin,
    output logic [19:0] Sum,
    output logic        Cout
);
    logic w_c;

    always_comb begin
        w_c = Cin;
        Sum = '0;
        for (int i = 0; i < 20; i++) begin
            Sum[i] = A[i] ^ B[i] ^ w_c;
            w_c    = (A[i] & B[i]) | (w_c & (A[i] ^ B[i]));
        end
        Cout = w_c;
    end
endmodule

module sum_accumulator #(
    parameter int OPERAND_COUNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [19:0] in_data,
    output logic        in_ready,
    output logic [19:0] acc_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [3:0] N_OPS   = 4'(OPERAND_COUNT);

    logic [1:0]  r_state;
    logic [19:0] r_acc;
    logic [3:0]  r_cnt;
    logic        r_ovf;

    logic [19:0] w_sum;
    logic        w_cout;
    logic [19:0] w_acc_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_xfer;
    logic        w_take;
    logic        w_last;

    ripple_adder20 u_add (
        .A    (r_acc),
        .B    (in_data),
        .Cin  (1'b0),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

`ifdef ACC_SATURATE_EN
    assign w_acc_nxt = w_cout ? 20'hFFFFF : w_sum;
`else
    assign w_acc_nxt = w_sum;
`endif

    assign in_ready  = (r_state != S_DONE);
    assign out_valid = (r_state == S_DONE);
    assign acc_out   = r_acc;
    assign overflow  = r_ovf;

    assign w_xfer    = in_valid & in_ready;
    assign w_take    = out_valid & out_ready;
    assign w_cnt_nxt = r_cnt + 4'd1;
    assign w_last    = (w_cnt_nxt == N_OPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_xfer) begin
                        r_acc   <= w_acc_nxt;
                        r_cnt   <= w_cnt_nxt;
                        r_ovf   <= r_ovf | w_cout;
                        r_state <= w_last ? S_DONE : S_ACCUM;
                    end
                end
                S_DONE: begin
                    if (w_take) begin
                        r_state <= S_IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_ovf   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: 4-operand instance plus a 1-operand instance.
// Expected values follow ACC_SATURATE_EN when it is defined for the build.

module tb_sum_accumulator;
    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [19:0] in_data;
    logic        in_ready;
    logic [19:0] acc_out;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;

    logic        in_valid1;
    logic [19:0] in_data1;
    logic        in_ready1;
    logic [19:0] acc_out1;
    logic        out_valid1;
    logic        out_ready1;
    logic        overflow1;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ACC_SATURATE_EN
    localparam logic [19:0] E_WRAP1 = 20'hFFFFF;
    localparam logic [19:0] E_WRAP2 = 20'hFFFFF;
`else
    localparam logic [19:0] E_WRAP1 = 20'h00001;
    localparam logic [19:0] E_WRAP2 = 20'h00002;
`endif

    sum_accumulator #(.OPERAND_COUNT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    sum_accumulator #(.OPERAND_COUNT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (1'b0),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
        .in_ready  (in_ready1),
        .acc_out   (acc_out1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .overflow  (overflow1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [19:0] got,
                         input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [19:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b0;

        #2;
        check("rst_ready", 20'(in_ready), 20'd1);
        check("rst_ovalid", 20'(out_valid), 20'd0);
        check("rst_acc", acc_out, 20'h0);
        check("rst_ovf", 20'(overflow), 20'd0);
        #11 rst_n = 1'b1;
        step();

        // 1+2+3+4 with latency check
        xfer(20'd1);
        xfer(20'd2);
        xfer(20'd3);
        check("sum_pre_valid", 20'(out_valid), 20'd0);
        check("sum_pre_acc", acc_out, 20'h00006);
        xfer(20'd4);
        check("sum_valid", 20'(out_valid), 20'd1);
        check("sum_acc", acc_out, 20'h0000A);
        check("sum_ovf", 20'(overflow), 20'd0);
        check("sum_ready", 20'(in_ready), 20'd0);

        // held result under backpressure with operands offered
        in_valid = 1'b1;
        in_data  = 20'd9;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_acc", acc_out, 20'h0000A);
            check("hold_ready", 20'(in_ready), 20'd0);
        end
        handshake();
        in_valid = 1'b0;
        check("take_valid", 20'(out_valid), 20'd0);
        check("take_acc", acc_out, 20'h0);
        check("take_ovf", 20'(overflow), 20'd0);
        check("take_ready", 20'(in_ready), 20'd1);

        // carry-out: wrap or saturate
        xfer(20'hFFFFF);
        xfer(20'h00002);
        check("ovf_mid_acc", acc_out, E_WRAP1);
        check("ovf_mid_flag", 20'(overflow), 20'd1);
        xfer(20'h0);
        xfer(20'h0);
        check("ovf_acc", acc_out, E_WRAP1);
        check("ovf_flag", 20'(overflow), 20'd1);
        check("ovf_valid", 20'(out_valid), 20'd1);
        handshake();
        check("ovf_cleared", 20'(overflow), 20'd0);

        // idle gaps between operands
        xfer(20'd5);
        step();
        step();
        check("gap_acc", acc_out, 20'h00005);
        check("gap_valid", 20'(out_valid), 20'd0);
        xfer(20'd1);
        xfer(20'd1);
        xfer(20'd1);
        check("gap_sum", acc_out, 20'h00008);
        check("gap_done", 20'(out_valid), 20'd1);
        handshake();

        // clear wins over a concurrent transfer
        xfer(20'd3);
        xfer(20'd3);
        check("clr_pre", acc_out, 20'h00006);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 20'd5;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_acc", acc_out, 20'h0);
        check("clr_valid", 20'(out_valid), 20'd0);
        check("clr_ready", 20'(in_ready), 20'd1);
        for (int i = 0; i < 4; i++) xfer(20'd1);
        check("clr_resum", acc_out, 20'h00004);
        check("clr_redone", 20'(out_valid), 20'd1);
        handshake();

        // asynchronous reset while a result is pending
        xfer(20'hFFFFF);
        xfer(20'h00003);
        xfer(20'h0);
        xfer(20'h0);
        check("ar_pre_acc", acc_out, E_WRAP2);
        check("ar_pre_valid", 20'(out_valid), 20'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 20'(out_valid), 20'd0);
        check("ar_acc", acc_out, 20'h0);
        check("ar_ovf", 20'(overflow), 20'd0);
        check("ar_ready", 20'(in_ready), 20'd1);
        in_valid = 1'b1;
        in_data  = 20'd7;
        #2 rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        check("ar_first_acc", acc_out, 20'h00007);
        check("ar_first_valid", 20'(out_valid), 20'd0);

        // single-operand instance, back to back
        in_valid1  = 1'b1;
        in_data1   = 20'd7;
        out_ready1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("n1_valid", 20'(out_valid1), (i % 2 == 0) ? 20'd1 : 20'd0);
            check("n1_acc", acc_out1, (i % 2 == 0) ? 20'h00007 : 20'h0);
        end
        in_valid1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
